jtframe_np1_frame: RTL and testbench



---
 rtl/jtframe_np1_frame_if.sv | 19 +
 rtl/jtframe_np1_frame.sv | 270 +++++++++++++++++++++++++++
 tb/tb_jtframe_np1_frame.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_np1_frame_if.sv
// DB9 joystick pins of the NP1 board. The board side is the master and the
// frame glue is the slave.
interface jtframe_np1_frame_if;
  logic joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i;
  logic joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i;
  logic joyX_p7_o;

  modport master (
    output joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i,
    output joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i,
    input  joyX_p7_o
  );

  modport slave (
    input  joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i,
    input  joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i,
    output joyX_p7_o
  );
endinterface

// File: rtl/jtframe_np1_frame.sv
// NP1 frame glue: frame/game resets, DB9 + PS/2 keyboard merged into
// active-low game controls, and OSD status decodes.
module jtframe_np1_frame #(
  parameter int BUTTONS = 2
) (
  input  logic        clk_sys,
  input  logic        pll_locked,
  input  logic [31:0] status,
  input  logic        downloading,
  inout  wire         ps2_kbd_clk,
  inout  wire         ps2_kbd_data,
  jtframe_np1_frame_if.slave db9,
  output logic        rst,
  output logic        rst_n,
  output logic        game_rst,
  output logic        game_rst_n,
  output logic [9:0]  game_joystick1,
  output logic [9:0]  game_joystick2,
  output logic [9:0]  game_joystick3,
  output logic [9:0]  game_joystick4,
  output logic [3:0]  game_coin,
  output logic [3:0]  game_start,
  output logic        dip_flip,
  output logic        dip_test,
  output logic        dip_pause,
  output logic        enable_fm,
  output logic        enable_psg,
  output logic [1:0]  dip_fxlevel,
  output logic [3:0]  gfx_en
);

  // Joystick bits above the last forwarded button always read released.
  localparam logic [9:0] FORCE_HI = 10'h3FF << (BUTTONS + 4);

  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic        rst_q, rst_d;
  logic [3:0]  grst_cnt_q, grst_cnt_d;
  logic        grst_q, grst_d;
  logic        grst_src;
  logic [5:0]  j1_s_q, j1_s_d, j2_s_q, j2_s_d;
  logic        kc_s1_q, kc_s2_q, kc_s3_q, kd_s1_q, kd_s2_q;
  logic        kc_fall;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  sr_q, sr_d;
  logic [11:0] tmo_q, tmo_d;
  logic [7:0]  code_q, code_d;
  logic        code_vld_q, code_vld_d;
  logic        ext_q, ext_d, rel_q, rel_d, mk;
  logic [6:0]  p1_keys_q, p1_keys_d;
  logic [5:0]  p2_keys_q, p2_keys_d;
  logic [1:0]  start_keys_q, start_keys_d, coin_keys_q, coin_keys_d;
  logic        pause_q, pause_d;
  logic [3:0]  gfx_q, gfx_d;
  logic [9:0]  joy1_q, joy1_d, joy2_q, joy2_d;
  logic [3:0]  coin_q, coin_d, start_q, start_d;
  logic        unused_status;

  assign ps2_kbd_clk    = 1'bz;
  assign ps2_kbd_data   = 1'bz;
  assign db9.joyX_p7_o  = 1'b1;
  assign grst_src       = rst_q | status[0] | downloading;
  assign kc_fall        = kc_s3_q & ~kc_s2_q;
  assign unused_status  = ^{status[31:11], status[5:2]};

  always_comb begin
    // Frame reset: count up after PLL lock, release when the count hits 15.
    rst_cnt_d = rst_cnt_q;
    rst_d     = rst_q;
    if (rst_q) begin
      if (rst_cnt_q == 4'hF) rst_d = 1'b0;
      else rst_cnt_d = rst_cnt_q + 4'd1;
    end

    grst_cnt_d = grst_cnt_q;
    grst_d     = grst_q;
    if (grst_src) begin
      grst_d     = 1'b1;
      grst_cnt_d = 4'd0;
    end else if (grst_q) begin
      if (grst_cnt_q == 4'hF) grst_d = 1'b0;
      grst_cnt_d = grst_cnt_q + 4'd1;
    end

    j1_s_d = {db9.joy1_p9_i, db9.joy1_p6_i, db9.joy1_up_i, db9.joy1_down_i,
              db9.joy1_left_i, db9.joy1_right_i};
    j2_s_d = {db9.joy2_p9_i, db9.joy2_p6_i, db9.joy2_up_i, db9.joy2_down_i,
              db9.joy2_left_i, db9.joy2_right_i};

    // PS/2 receiver: sr collects start, data and parity; the stop bit is
    // checked live on the eleventh falling edge.
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    tmo_d      = tmo_q + 12'd1;
    code_d     = code_q;
    code_vld_d = 1'b0;
    if (kc_fall) begin
      tmo_d = 12'd0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!sr_q[0] && (^sr_q[9:1]) && kd_s2_q) begin
          code_vld_d = 1'b1;
          code_d     = sr_q[8:1];
        end
      end else begin
        sr_d      = {kd_s2_q, sr_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (tmo_q == 12'hFFF) begin
      bit_cnt_d = 4'd0;
      tmo_d     = 12'd0;
    end
    if (rst_q) begin
      bit_cnt_d  = 4'd0;
      code_vld_d = 1'b0;
    end

    ext_d        = ext_q;
    rel_d        = rel_q;
    p1_keys_d    = p1_keys_q;
    p2_keys_d    = p2_keys_q;
    start_keys_d = start_keys_q;
    coin_keys_d  = coin_keys_q;
    pause_d      = pause_q;
    gfx_d        = gfx_q;
    mk           = ~rel_q;
    if (rst_q) begin
      ext_d        = 1'b0;
      rel_d        = 1'b0;
      p1_keys_d    = '0;
      p2_keys_d    = '0;
      start_keys_d = '0;
      coin_keys_d  = '0;
      pause_d      = 1'b1;
      gfx_d        = 4'hF;
    end else if (code_vld_q) begin
      if (code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (code_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
        // Arrow codes without E0 are keypad keys and are ignored.
        if (ext_q) begin
          case (code_q)
            8'h75: p1_keys_d[3] = mk;
            8'h72: p1_keys_d[2] = mk;
            8'h6B: p1_keys_d[1] = mk;
            8'h74: p1_keys_d[0] = mk;
            default: ;
          endcase
        end
        case (code_q)
          8'h14: p1_keys_d[4]    = mk;
          8'h11: p1_keys_d[5]    = mk;
          8'h29: p1_keys_d[6]    = mk;
          8'h2D: p2_keys_d[3]    = mk;
          8'h2B: p2_keys_d[2]    = mk;
          8'h23: p2_keys_d[1]    = mk;
          8'h34: p2_keys_d[0]    = mk;
          8'h1C: p2_keys_d[4]    = mk;
          8'h1B: p2_keys_d[5]    = mk;
          8'h16: start_keys_d[0] = mk;
          8'h1E: start_keys_d[1] = mk;
          8'h2E: coin_keys_d[0]  = mk;
          8'h36: coin_keys_d[1]  = mk;
          8'h4D: if (mk) pause_d  = ~pause_q;
          8'h01: if (mk) gfx_d[0] = ~gfx_q[0];
          8'h09: if (mk) gfx_d[1] = ~gfx_q[1];
          8'h78: if (mk) gfx_d[2] = ~gfx_q[2];
          8'h07: if (mk) gfx_d[3] = ~gfx_q[3];
          default: ;
        endcase
      end
    end

    // The output register doubles as the second DB9 synchronizer stage.
    joy1_d  = ({4'hF, j1_s_q} & ~{3'b000, p1_keys_q}) | FORCE_HI;
    joy2_d  = ({4'hF, j2_s_q} & ~{4'b0000, p2_keys_q}) | FORCE_HI;
    coin_d  = {2'b11, ~coin_keys_q};
    start_d = {2'b11, ~start_keys_q};
    if (rst_q) begin
      joy1_d  = 10'h3FF;
      joy2_d  = 10'h3FF;
      coin_d  = 4'hF;
      start_d = 4'hF;
    end
  end

  always_ff @(posedge clk_sys or negedge pll_locked) begin
    if (!pll_locked) begin
      rst_cnt_q    <= 4'd0;
      rst_q        <= 1'b1;
      grst_cnt_q   <= 4'd0;
      grst_q       <= 1'b1;
      j1_s_q       <= 6'h3F;
      j2_s_q       <= 6'h3F;
      kc_s1_q      <= 1'b1;
      kc_s2_q      <= 1'b1;
      kc_s3_q      <= 1'b1;
      kd_s1_q      <= 1'b1;
      kd_s2_q      <= 1'b1;
      bit_cnt_q    <= 4'd0;
      sr_q         <= '0;
      tmo_q        <= '0;
      code_q       <= '0;
      code_vld_q   <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      p1_keys_q    <= '0;
      p2_keys_q    <= '0;
      start_keys_q <= '0;
      coin_keys_q  <= '0;
      pause_q      <= 1'b1;
      gfx_q        <= 4'hF;
      joy1_q       <= 10'h3FF;
      joy2_q       <= 10'h3FF;
      coin_q       <= 4'hF;
      start_q      <= 4'hF;
    end else begin
      rst_cnt_q    <= rst_cnt_d;
      rst_q        <= rst_d;
      grst_cnt_q   <= grst_cnt_d;
      grst_q       <= grst_d;
      j1_s_q       <= j1_s_d;
      j2_s_q       <= j2_s_d;
      kc_s1_q      <= ps2_kbd_clk;
      kc_s2_q      <= kc_s1_q;
      kc_s3_q      <= kc_s2_q;
      kd_s1_q      <= ps2_kbd_data;
      kd_s2_q      <= kd_s1_q;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      code_vld_q   <= code_vld_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      p1_keys_q    <= p1_keys_d;
      p2_keys_q    <= p2_keys_d;
      start_keys_q <= start_keys_d;
      coin_keys_q  <= coin_keys_d;
      pause_q      <= pause_d;
      gfx_q        <= gfx_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
      coin_q       <= coin_d;
      start_q      <= start_d;
    end
  end

  assign rst            = rst_q;
  assign rst_n          = ~rst_q;
  assign game_rst       = grst_q | grst_src;
  assign game_rst_n     = ~game_rst;
  assign game_joystick1 = joy1_q;
  assign game_joystick2 = joy2_q;
  assign game_joystick3 = 10'h3FF;
  assign game_joystick4 = 10'h3FF;
  assign game_coin      = coin_q;
  assign game_start     = start_q;
  assign dip_pause      = pause_q;
  assign gfx_en         = gfx_q;
  assign dip_flip       = status[1];
  assign dip_test       = ~status[10];
  assign enable_psg     = ~status[8];
  assign enable_fm      = ~status[9];
  assign dip_fxlevel    = status[7:6] ^ 2'b10;

endmodule

// File: tb/tb_jtframe_np1_frame.sv
// Bench for jtframe_np1_frame: directed reset/DB9/PS/2 cases, then random
// key and pin traffic checked against a keyboard-state model.
module tb_jtframe_np1_frame;
  localparam int BUTTONS = 2;

  logic        clk_sys = 1'b0;
  logic        pll_locked = 1'b1;
  logic [31:0] status = 32'h0;
  logic        downloading = 1'b0;
  logic        ps2_clk_drv = 1'b1, ps2_dat_drv = 1'b1;
  wire         ps2_kbd_clk, ps2_kbd_data;
  logic        rst, rst_n, game_rst, game_rst_n;
  logic [9:0]  game_joystick1, game_joystick2, game_joystick3, game_joystick4;
  logic [3:0]  game_coin, game_start, gfx_en;
  logic        dip_flip, dip_test, dip_pause, enable_fm, enable_psg;
  logic [1:0]  dip_fxlevel;

  assign ps2_kbd_clk  = ps2_clk_drv;
  assign ps2_kbd_data = ps2_dat_drv;

  jtframe_np1_frame_if db9 ();

  jtframe_np1_frame #(.BUTTONS(BUTTONS)) dut (
    .clk_sys(clk_sys), .pll_locked(pll_locked), .status(status),
    .downloading(downloading), .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data),
    .db9(db9), .rst(rst), .rst_n(rst_n), .game_rst(game_rst), .game_rst_n(game_rst_n),
    .game_joystick1(game_joystick1), .game_joystick2(game_joystick2),
    .game_joystick3(game_joystick3), .game_joystick4(game_joystick4),
    .game_coin(game_coin), .game_start(game_start), .dip_flip(dip_flip),
    .dip_test(dip_test), .dip_pause(dip_pause), .enable_fm(enable_fm),
    .enable_psg(enable_psg), .dip_fxlevel(dip_fxlevel), .gfx_en(gfx_en)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- keyboard model ----------------
  bit       pressed [256];
  bit       m_ext, m_rel, m_pause;
  bit [3:0] m_gfx;

  function automatic bit is_arrow(input logic [7:0] c);
    return c == 8'h75 || c == 8'h72 || c == 8'h6B || c == 8'h74;
  endfunction

  task automatic model_reset();
    foreach (pressed[i]) pressed[i] = 1'b0;
    m_ext = 0; m_rel = 0; m_pause = 1; m_gfx = 4'hF;
  endtask

  task automatic model_frame(input logic [7:0] c);
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_rel = 1;
    else begin
      if (!(is_arrow(c) && !m_ext)) pressed[c] = !m_rel;
      if (!m_rel) begin
        if (c == 8'h4D) m_pause = !m_pause;
        if (c == 8'h01) m_gfx[0] = !m_gfx[0];
        if (c == 8'h09) m_gfx[1] = !m_gfx[1];
        if (c == 8'h78) m_gfx[2] = !m_gfx[2];
        if (c == 8'h07) m_gfx[3] = !m_gfx[3];
      end
      m_ext = 0; m_rel = 0;
    end
  endtask

  function automatic logic [9:0] force_hi(input logic [9:0] v);
    logic [9:0] r = v;
    for (int i = 0; i < 10; i++) if (i > BUTTONS + 3) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [9:0] exp_j1();
    logic [9:0] v;
    v[0] = db9.joy1_right_i & ~pressed[8'h74];
    v[1] = db9.joy1_left_i  & ~pressed[8'h6B];
    v[2] = db9.joy1_down_i  & ~pressed[8'h72];
    v[3] = db9.joy1_up_i    & ~pressed[8'h75];
    v[4] = db9.joy1_p6_i    & ~pressed[8'h14];
    v[5] = db9.joy1_p9_i    & ~pressed[8'h11];
    v[6] = ~pressed[8'h29];
    v[9:7] = 3'b111;
    return force_hi(v);
  endfunction

  function automatic logic [9:0] exp_j2();
    logic [9:0] v;
    v[0] = db9.joy2_right_i & ~pressed[8'h34];
    v[1] = db9.joy2_left_i  & ~pressed[8'h23];
    v[2] = db9.joy2_down_i  & ~pressed[8'h2B];
    v[3] = db9.joy2_up_i    & ~pressed[8'h2D];
    v[4] = db9.joy2_p6_i    & ~pressed[8'h1C];
    v[5] = db9.joy2_p9_i    & ~pressed[8'h1B];
    v[9:6] = 4'hF;
    return force_hi(v);
  endfunction

  function automatic logic [3:0] exp_coin();
    return {2'b11, ~pressed[8'h36], ~pressed[8'h2E]};
  endfunction

  function automatic logic [3:0] exp_start();
    return {2'b11, ~pressed[8'h1E], ~pressed[8'h16]};
  endfunction

  // ---------------- drivers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat_drv = b;
    repeat (4) @(posedge clk_sys);
    ps2_clk_drv = 1'b0;
    repeat (8) @(posedge clk_sys);
    ps2_clk_drv = 1'b1;
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad_par);
    logic par;
    par = ~(^c) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    if (!bad_par) model_frame(c);
    cycles(12);
  endtask

  task automatic send_key(input logic [7:0] c, input bit ext, input bit brk);
    if (ext) send_frame(8'hE0, 0);
    if (brk) send_frame(8'hF0, 0);
    send_frame(c, 0);
  endtask

  task automatic set_db9(input logic [11:0] v);
    {db9.joy1_up_i, db9.joy1_down_i, db9.joy1_left_i, db9.joy1_right_i,
     db9.joy1_p6_i, db9.joy1_p9_i} = v[11:6];
    {db9.joy2_up_i, db9.joy2_down_i, db9.joy2_left_i, db9.joy2_right_i,
     db9.joy2_p6_i, db9.joy2_p9_i} = v[5:0];
  endtask

  task automatic count_until_low(input string tag, input bit which, input int exp_n);
    int n = 0;
    do begin
      @(posedge clk_sys); n++; @(negedge clk_sys);
    end while ((which ? game_rst : rst) && n < 100);
    check_val(tag, n, exp_n);
  endtask

  task automatic check_all(input string pfx);
    exp_q.push_back({22'd0, exp_j1()});
    exp_q.push_back({22'd0, exp_j2()});
    exp_q.push_back({28'd0, exp_coin()});
    exp_q.push_back({28'd0, exp_start()});
    exp_q.push_back({31'd0, m_pause});
    exp_q.push_back({28'd0, m_gfx});
    check_val({pfx, "_j1"},    {22'd0, game_joystick1}, exp_q.pop_front());
    check_val({pfx, "_j2"},    {22'd0, game_joystick2}, exp_q.pop_front());
    check_val({pfx, "_coin"},  {28'd0, game_coin},      exp_q.pop_front());
    check_val({pfx, "_start"}, {28'd0, game_start},     exp_q.pop_front());
    check_val({pfx, "_pause"}, {31'd0, dip_pause},      exp_q.pop_front());
    check_val({pfx, "_gfx"},   {28'd0, gfx_en},         exp_q.pop_front());
  endtask

  logic [7:0] tbl [23] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h2D,
                           8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h16, 8'h1E, 8'h2E,
                           8'h36, 8'h4D, 8'h01, 8'h09, 8'h78, 8'h07, 8'h5A};

  initial begin
    set_db9(12'hFFF);
    model_reset();
    #2 pll_locked = 1'b0;
    cycles(3);
    check_val("reset_rst", {30'd0, rst, rst_n}, 32'h2);
    check_val("reset_game_rst", {30'd0, game_rst, game_rst_n}, 32'h2);
    check_all("reset");
    check_val("reset_j34", {game_joystick3, game_joystick4}, 32'hFFFFF);
    check_val("p7", {31'd0, db9.joyX_p7_o}, 32'h1);

    pll_locked = 1'b1;
    count_until_low("rst_release", 0, 16);
    check_val("rst_n_after", {31'd0, rst_n}, 32'h1);
    count_until_low("game_rst_release", 1, 16);
    check_val("game_rst_n_after", {31'd0, game_rst_n}, 32'h1);

    status[0] = 1'b1;
    #1 check_val("status0_assert", {31'd0, game_rst}, 32'h1);
    cycles(1);
    status[0] = 1'b0;
    count_until_low("status0_hold", 1, 16);
    downloading = 1'b1;
    cycles(3);
    downloading = 1'b0;
    count_until_low("download_hold", 1, 16);

    // DB9 mapping and latency
    db9.joy1_up_i = 1'b0; db9.joy2_p9_i = 1'b0;
    cycles(1);
    check_val("db9_lat1_j1", {22'd0, game_joystick1}, 32'h3FF);
    cycles(1);
    check_val("db9_j1", {22'd0, game_joystick1}, 32'h3F7);
    check_val("db9_j2", {22'd0, game_joystick2}, 32'h3DF);

    // both sources on up, release only the key
    send_key(8'h75, 1, 0);
    check_val("both_up", {31'd0, game_joystick1[3]}, 32'h0);
    send_key(8'h75, 1, 1);
    check_val("key_rel_db9_held", {31'd0, game_joystick1[3]}, 32'h0);
    set_db9(12'hFFF);
    cycles(3);

    send_key(8'h75, 1, 0);
    check_val("arrow_up_make", {31'd0, game_joystick1[3]}, 32'h0);
    send_key(8'h75, 1, 1);
    check_val("arrow_up_break", {31'd0, game_joystick1[3]}, 32'h1);

    send_frame(8'h2E, 1);
    check_val("coin_bad_parity", {28'd0, game_coin}, 32'hF);
    send_frame(8'h2E, 0);
    check_val("coin_good", {28'd0, game_coin}, 32'hE);
    send_key(8'h2E, 0, 1);
    check_val("coin_release", {28'd0, game_coin}, 32'hF);

    send_key(8'h4D, 0, 0);
    check_val("pause_1", {31'd0, dip_pause}, 32'h0);
    send_key(8'h4D, 0, 0);
    check_val("pause_2", {31'd0, dip_pause}, 32'h1);
    send_key(8'h01, 0, 0);
    check_val("gfx_f9", {28'd0, gfx_en}, 32'hE);

    status = 32'h0000_0702;
    #1;
    check_val("status_decode", {27'd0, dip_flip, dip_test, enable_psg, enable_fm, dip_fxlevel},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
    status = 32'h0;

    // partial frame then inactivity: bit counter must resynchronise
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    cycles(4200);
    send_frame(8'h1E, 0);
    check_val("timeout_resync", {28'd0, game_start}, 32'hD);

    // reset mid-frame clears key state and drops the partial frame
    send_key(8'h16, 0, 0);
    check_val("start1_held", {28'd0, game_start}, 32'hC);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    pll_locked = 1'b0;
    cycles(2);
    model_reset();
    check_all("midreset");
    pll_locked = 1'b1;
    count_until_low("rst_release2", 0, 16);
    count_until_low("game_rst_release2", 1, 16);
    send_frame(8'h2E, 0);
    check_val("after_midreset_coin", {28'd0, game_coin}, 32'hE);
    check_all("after_midreset");

    // random traffic
    for (int it = 0; it < 40; it++) begin
      int act;
      int idx;
      act = $urandom_range(0, 5);
      if (act <= 2) begin
        idx = $urandom_range(0, 22);
        send_key(tbl[idx], idx < 4, $urandom_range(0, 1) == 1);
      end else if (act == 3) begin
        set_db9(12'($urandom));
        cycles(3);
      end else if (act == 4) begin
        send_frame(tbl[$urandom_range(0, 22)], 1);
      end else begin
        status = $urandom & 32'hFFFF_FFFE;
        #1;
        check_val("rnd_status", {27'd0, dip_flip, dip_test, enable_psg, enable_fm, dip_fxlevel},
                  {27'd0, status[1], ~status[10], ~status[8], ~status[9], status[7:6] ^ 2'b10});
      end
      check_all("rnd");
      check_val("rnd_game_rst", {31'd0, game_rst}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
